bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter DATA_W, default 8: parallel word width, legal range 2..32.
REQ-002 Parameter PARITY_EN, default 0: 1 appends one parity bit after each word.
REQ-003 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port s_data, input, DATA_W: parallel word to serialize.
REQ-007 Port s_valid, input, 1: s_data is valid.
REQ-008 Port s_ready, output, 1: block accepts s_data this cycle.
REQ-009 Port ser_out, output, 1: serial bit stream, MSB first.
REQ-010 Port ser_valid, output, 1: ser_out carries a frame bit this cycle.
REQ-011 Port ser_last, output, 1: this is the final bit of the current frame.
REQ-012 Port busy, output, 1: FSM is not in IDLE.

Function
REQ-013 A transfer occurs on a rising edge where s_valid=1 and s_ready=1; no other edge captures s_data.
REQ-014 The FSM has three states: IDLE, SHIFT and PAR. PAR is unreachable when PARITY_EN=0.
REQ-015 IDLE -> SHIFT on a transfer; IDLE holds otherwise.
REQ-016 On a transfer, the shift register loads s_data, the bit counter loads DATA_W-1, and parity accumulation restarts.
REQ-017 Latency: the first bit (s_data[DATA_W-1]) appears on ser_out with ser_valid=1 in the cycle after the transfer edge.
REQ-018 In SHIFT, the block presents one bit per cycle with no stall, then shifts left and decrements the counter.
REQ-019 At counter 0 with PARITY_EN=0: ser_last=1, and the FSM goes to SHIFT on a transfer, otherwise to IDLE.
REQ-020 At counter 0 with PARITY_EN=1: the FSM goes to PAR.
REQ-021 In PAR, ser_out equals the XOR of all DATA_W bits XOR PARITY_ODD, with ser_valid=1 and ser_last=1; the next state is SHIFT on a transfer, otherwise IDLE.
REQ-022 s_ready is combinational and equals 1 in IDLE and in the ser_last cycle, 0 otherwise; this allows back-to-back frames with zero bubble cycles.
REQ-023 ser_out, ser_valid and ser_last are registered outputs; busy is decoded from state.
REQ-024 When ser_valid=0, ser_out shall be 0.
REQ-025 A frame is DATA_W bits, or DATA_W+1 bits when PARITY_EN=1; no frame is ever truncated or extended.
REQ-026 The counter is $clog2(DATA_W) bits wide and never wraps below 0.
REQ-027 Changes on s_data or s_valid outside transfer edges have no effect on the frame in progress.

Reset
REQ-028 reset_n low immediately forces state=IDLE, ser_out=0, ser_valid=0, ser_last=0, busy=0, shift register=0 and counter=0.
REQ-029 reset_n low during a frame aborts it; no remaining bits are emitted after release.
REQ-030 Transfers are ignored while reset_n is low; the first transfer is possible on the first edge after release.

Structure
REQ-031 Package bit_serializer_pkg holds the state encoding (IDLE=2'b00, SHIFT=2'b01, PAR=2'b10) and the counter-width function.
REQ-032 The block is a single module with no sub-module; parity is computed inline.

Verification
REQ-033 DATA_W=8, PARITY_EN=0, send 0xA5 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles starting at transfer+1, ser_last on the 8th cycle, then IDLE.
REQ-034 Send 0xFF then 0x00 back-to-back with s_valid held high -> 16 contiguous ser_valid cycles; 8 ones then 8 zeros; s_ready high only in the two ser_last cycles.
REQ-035 PARITY_EN=1, PARITY_ODD=0, send 0x07 -> 9-bit frame 0,0,0,0,0,1,1,1,1; PARITY_ODD=1 gives a final bit of 0.
REQ-036 Assert reset_n low at bit 3 of 0xC3 -> outputs are 0 in the same cycle; after release, no further ser_valid until a new transfer.
REQ-037 Hold s_valid=0 for 10 cycles after reset -> ser_valid=0, ser_out=0, busy=0 and s_ready=1 throughout.
REQ-038 Toggle s_data mid-frame while s_valid=1 and s_ready=0 -> frame bits unchanged, and the next frame carries the value present at the ser_last edge.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bit_serializer_pkg : state encoding and counter sizing for bit_serializer
// Rev 1.0
// ---------------------------------------------------------------------------
package bit_serializer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_PAR   = 2'b10;

  // Bit counter width; never below one bit so the counter always exists.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bit_serializer : MSB-first parallel-to-serial converter, optional parity
// Rev 1.0
// ---------------------------------------------------------------------------
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy
);

  localparam int                CNT_W     = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0]  C_CNT_MAX = CNT_W'(DATA_W - 1);
  localparam logic              C_PAR_EN  = (PARITY_EN != 0);
  localparam logic              C_PAR_ODD = (PARITY_ODD != 0);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_par;
  logic              r_ser_out;
  logic              r_ser_valid;
  logic              r_ser_last;

  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] w_shreg_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_par_nxt;
  logic              w_xfer;
  logic              w_load;

  assign s_ready   = (r_state == ST_IDLE) || r_ser_last;
  assign w_xfer    = s_valid && s_ready;
  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign ser_last  = r_ser_last;
  assign busy      = (r_state != ST_IDLE);

  // Parity accumulates each bit as it leaves the output, so the PAR cycle
  // sees the XOR of the whole word.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_par_nxt   = r_par;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) w_load = 1'b1;
      end
      ST_SHIFT: begin
        w_par_nxt = r_par ^ r_shreg[DATA_W-1];
        if (r_cnt != '0) begin
          w_shreg_nxt = {r_shreg[DATA_W-2:0], 1'b0};
          w_cnt_nxt   = r_cnt - 1'b1;
        end else if (C_PAR_EN) begin
          w_state_nxt = ST_PAR;
        end else if (w_xfer) begin
          w_load = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PAR: begin
        if (w_xfer) w_load = 1'b1;
        else        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_load) begin
      w_state_nxt = ST_SHIFT;
      w_shreg_nxt = s_data;
      w_cnt_nxt   = C_CNT_MAX;
      w_par_nxt   = 1'b0;
    end
  end

  // Output registers are driven from next-state values so the first bit
  // appears in the cycle right after the transfer edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_par       <= 1'b0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_cnt       <= w_cnt_nxt;
      r_par       <= w_par_nxt;
      r_ser_valid <= (w_state_nxt != ST_IDLE);
      r_ser_out   <= (w_state_nxt == ST_SHIFT) ? w_shreg_nxt[DATA_W-1] :
                     (w_state_nxt == ST_PAR)   ? (w_par_nxt ^ C_PAR_ODD) : 1'b0;
      r_ser_last  <= ((w_state_nxt == ST_SHIFT) && (w_cnt_nxt == '0) && !C_PAR_EN) ||
                     (w_state_nxt == ST_PAR);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bit_serializer : three parity configurations against a bit-queue model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bit_serializer;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       s_valid = 1'b0;
  logic [2:0] rdy, sv, so, sl, bz;

  always #5 clk = ~clk;

  // dut0: no parity, dut1: even parity, dut2: odd parity
  bit_serializer #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(rdy[0]), .ser_out(so[0]), .ser_valid(sv[0]), .ser_last(sl[0]), .busy(bz[0]));
  bit_serializer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(rdy[1]), .ser_out(so[1]), .ser_valid(sv[1]), .ser_last(sl[1]), .busy(bz[1]));
  bit_serializer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(rdy[2]), .ser_out(so[2]), .ser_valid(sv[2]), .ser_last(sl[2]), .busy(bz[2]));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: per instance, the list of {last, bit} still to appear on the wire.
  logic [1:0]  mbuf [3][32];
  int          mlen [3] = '{0, 0, 0};
  logic [63:0] cap  [3] = '{64'd0, 64'd0, 64'd0};
  int          ccnt [3] = '{0, 0, 0};
  int          rdy_cnt = 0;

  task automatic check(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int k = 0; k < 3; k++) mlen[k] = 0;
      end else begin
        for (int k = 0; k < 3; k++) begin
          logic rdy_m;
          rdy_m = (mlen[k] == 0) || mbuf[k][0][1];
          if (mlen[k] > 0) begin
            for (int j = 0; j < 31; j++) mbuf[k][j] = mbuf[k][j+1];
            mlen[k]--;
          end
          if (s_valid && rdy_m) begin
            for (int i = 7; i >= 0; i--) begin
              mbuf[k][mlen[k]] = {(i == 0) && (k == 0), s_data[i]};
              mlen[k]++;
            end
            if (k != 0) begin
              mbuf[k][mlen[k]] = {1'b1, (^s_data) ^ (k == 2)};
              mlen[k]++;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        logic eb, el;
        eb = (mlen[k] > 0) ? mbuf[k][0][0] : 1'b0;
        el = (mlen[k] > 0) ? mbuf[k][0][1] : 1'b0;
        check("ser_valid", k, 64'(sv[k]), 64'(mlen[k] > 0));
        check("ser_out",   k, 64'(so[k]), 64'(eb));
        check("ser_last",  k, 64'(sl[k]), 64'(el));
        check("s_ready",   k, 64'(rdy[k]), 64'((mlen[k] == 0) || el));
        check("busy",      k, 64'(bz[k]), 64'(mlen[k] > 0));
        if (sv[k] === 1'b1) begin
          cap[k] = {cap[k][62:0], so[k]};
          ccnt[k]++;
        end
      end
      if (sv[0] === 1'b1 && rdy[0] === 1'b1) rdy_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr_cap();
    for (int k = 0; k < 3; k++) begin
      cap[k]  = 64'd0;
      ccnt[k] = 0;
    end
    rdy_cnt = 0;
  endtask

  task automatic send_one(input logic [7:0] d);
    clr_cap();
    s_valid = 1'b1;
    s_data  = d;
    cyc(1);
    s_valid = 1'b0;
    cyc(12);
  endtask

  initial begin
    cyc(3);
    reset_n = 1'b1;
    clr_cap();
    cyc(10);
    check("idle_ready", 0, 64'(rdy), 64'h7);
    check("idle_busy", 0, 64'(bz), 64'h0);
    check("idle_no_frames", 0, 64'(ccnt[0] + ccnt[1] + ccnt[2]), 64'd0);

    send_one(8'hA5);
    check("a5_bits", 0, cap[0], 64'hA5);
    check("a5_len",  0, 64'(ccnt[0]), 64'd8);
    check("a5_bits", 1, cap[1], 64'h14A);
    check("a5_bits", 2, cap[2], 64'h14B);

    send_one(8'h07);
    check("07_bits", 0, cap[0], 64'h007);
    check("07_bits", 1, cap[1], 64'h00F);
    check("07_len",  1, 64'(ccnt[1]), 64'd9);
    check("07_bits", 2, cap[2], 64'h00E);

    // Back-to-back FF then 00 with s_valid held across the ser_last edge.
    clr_cap();
    s_valid = 1'b1;
    s_data  = 8'hFF;
    cyc(1);
    s_data  = 8'h00;
    cyc(8);
    s_valid = 1'b0;
    cyc(12);
    check("b2b_bits",  0, cap[0], 64'hFF00);
    check("b2b_len",   0, 64'(ccnt[0]), 64'd16);
    check("b2b_ready", 0, 64'(rdy_cnt), 64'd2);
    check("b2b_bits",  1, cap[1], 64'h1FE);
    check("b2b_bits",  2, cap[2], 64'h1FF);

    // s_data churns mid-frame; only the value at the ser_last edge is taken.
    clr_cap();
    s_valid = 1'b1;
    s_data  = 8'h3C;
    cyc(1);
    repeat (7) begin
      s_data = 8'($urandom);
      cyc(1);
    end
    s_data = 8'h5A;
    cyc(1);
    s_valid = 1'b0;
    cyc(14);
    check("toggle_bits", 0, cap[0], 64'h3C5A);

    // Reset mid-frame: outputs drop immediately, nothing resumes afterwards.
    clr_cap();
    s_valid = 1'b1;
    s_data  = 8'hC3;
    cyc(1);
    s_valid = 1'b0;
    cyc(3);
    reset_n = 1'b0;
    #1;
    check("reset_async", 0, 64'({sv, so, sl, bz}), 64'h0);
    s_valid = 1'b1;
    cyc(2);
    s_valid = 1'b0;
    reset_n = 1'b1;
    clr_cap();
    cyc(12);
    check("abort_no_tail", 0, 64'(ccnt[0] + ccnt[1] + ccnt[2]), 64'd0);

    // First edge after release accepts a transfer.
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    send_one(8'h81);
    check("post_reset_bits", 0, cap[0], 64'h81);

    for (int i = 0; i < 400; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      cyc(1);
    end
    s_valid = 1'b0;
    cyc(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
